regfile_sb: RTL
===============

# regfile_sb

Parametrised register file for the MCU datapath, replacing the fixed 16×32 file. It provides two combinational read ports with same-cycle write-through bypass and two write ports: port 0 for ALU writeback, port 1 for load writeback. A per-register busy scoreboard tracks outstanding multi-cycle loads, and a dedicated PC register has its own update path. It sits between decode (reads, reservations) and writeback (writes), and feeds the fetch stage via `pc_out`.

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 4, register address width; `NREGS = 2**ADDR_W`
- `PC_IDX`, `NREGS-1`, index of the PC register
- `RESET_PC`, 0, PC value after reset
- `ZERO_R0`, 0, if 1: register 0 always reads 0, never goes busy, and ignores writes and reservations

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `rd_addr_a`, `rd_addr_b`  in  ADDR_W  read addresses
- `rd_data_a`, `rd_data_b`  out  DATA_W  read data (combinational, bypassed)
- `rd_busy_a`, `rd_busy_b`  out  1  addressed register has a pending load
- `wr0_en` in 1, `wr0_addr` in ADDR_W, `wr0_data` in DATA_W  ALU write port
- `wr1_en` in 1, `wr1_addr` in ADDR_W, `wr1_data` in DATA_W  load write port; also completes a reservation
- `resv_en` in 1, `resv_addr` in ADDR_W  mark register busy (load issued)
- `pc_we`  in  1  load `pc_next` into PC
- `pc_next`  in  DATA_W  next PC value
- `pc_out`  out  DATA_W  current PC register value
- `busy_any`  out  1  OR of all busy bits
- `err_waw`  out  1  one-cycle pulse on a write-port collision

## Operation
- State: `regs[NREGS]` (DATA_W each) and `busy[NREGS]`.
- Reset (`rst_n`=0, asynchronous):
  - all `regs` = 0, except `regs[PC_IDX]` = RESET_PC;
  - `busy` = 0 and `err_waw` = 0;
  - so `pc_out` = RESET_PC and `busy_any` = 0.
- Write priority per target register, highest first: wr0, wr1, pc_we.
  - pc_we writes `regs[PC_IDX]` only. It is overridden when wr0 or wr1 targets PC_IDX in the same cycle.
  - Without pc_we or a port write, PC holds its value. There is no implicit per-cycle overwrite.
- Collision: `wr0_en & wr1_en & (wr0_addr==wr1_addr)` means wr0 data is written, wr1 data is dropped, and `err_waw`=1 in the next cycle. The busy clear from wr1 still occurs.
- Scoreboard (per register r, next state):
  - set if `resv_en & resv_addr==r`;
  - else cleared if `wr1_en & wr1_addr==r`;
  - else held.
  - A reservation and a completion to the same register in the same cycle leave it busy (the new load wins).
  - wr0 does not change busy.
  - `resv_en` on an already-busy register leaves it busy (idempotent).
- Read mux per port, first match wins:
  - ZERO_R0 & addr==0 gives 0;
  - wr0 hit (`wr0_en` & addr match) gives `wr0_data`;
  - wr1 hit gives `wr1_data`;
  - PC_IDX & pc_we gives `pc_next`;
  - otherwise `regs[addr]`.
- `rd_busy_x` = `busy[addr] & ~(wr1_en & wr1_addr==addr)`. A completing load is bypassed, so the register reads not-busy. With ZERO_R0=1, address 0 always reads not-busy.
- `pc_out` = `regs[PC_IDX]` (registered, no bypass).

## Timing
- Read data and busy flags have 0-cycle latency: they are combinational from addresses and the current-cycle write inputs.
- Writes, reservations and PC updates commit at the rising edge and are visible in `regs`, `busy` and `pc_out` from the next cycle.
- `err_waw` is registered: high for exactly the cycle after a collision.
- `busy_any` is combinational from the `busy` register, so it updates one cycle after the edge that sets or clears a bit.
- Reset asserted mid-operation clears all pending reservations immediately. A wr1 arriving after reset release writes data normally and has no busy effect.

## Structure
- Package `regfile_pkg` holds:
  - default `DATA_W` and `ADDR_W`;
  - the `reg_addr_t` and `reg_data_t` typedefs;
  - the `PC_IDX` default;
  - the `RESET_PC` default.
- Sub-module `regfile_scoreboard` (the busy vector with set/clear priority, `busy_any`, and per-port `rd_busy`) is instantiated once. Storage, write priority and bypass muxes stay in the top level.

## Test plan
- Reset, then read every address → all reads 0 except PC_IDX=RESET_PC; `pc_out`=RESET_PC; `busy_any`=0.
- `wr0` r3=0x1234 while `rd_addr_a`=3 in the same cycle → `rd_data_a`=0x1234 combinationally; the next cycle reads 0x1234 from storage.
- `resv` r5, then 3 idle cycles, then `wr1` r5=0xAA → `rd_busy`(5)=1 for cycles 1–3 and 0 in the wr1 cycle (bypass); `rd_data`=0xAA; `busy_any` falls one cycle later.
- `wr0` r2=0x11 and `wr1` r2=0x22 in the same cycle, with r2 previously reserved → r2=0x11; `err_waw` pulses for one cycle; r2 is not busy.
- `pc_we`=1 with `pc_next`=0x40 while `wr0` targets PC_IDX with 0x80 → `pc_out`=0x80 next cycle. Then idle → PC holds 0x80. Then `pc_we` with 0x84 → `pc_out`=0x84.
- ZERO_R0=1: `wr0` r0=0xFF and `resv` r0 → r0 reads 0 and not-busy. Then assert `rst_n` low mid-reservation on r7 → busy bit clears asynchronously.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;

  // The PC register sits at the top index of the file.
  function automatic int pc_idx_of(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

  localparam int PC_IDX_DEF   = pc_idx_of(ADDR_W_DEF);
  localparam int RESET_PC_DEF = 0;

  typedef logic [DATA_W_DEF-1:0] reg_data_t;
  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for outstanding loads, with completion bypass on the read flags.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              resv_en,
  input  logic [ADDR_W-1:0] resv_addr,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  output logic              busy_any
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  // A reservation beats a completion to the same register: the new load is still pending.
  always_comb begin
    busy_nxt = busy;
    for (int r = 0; r < NREGS; r++) begin
      if (resv_en && resv_addr == ADDR_W'(r))
        busy_nxt[r] = 1'b1;
      else if (wr1_en && wr1_addr == ADDR_W'(r))
        busy_nxt[r] = 1'b0;
    end
    if (ZERO_R0 != 0)
      busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  assign rd_busy_a = busy[rd_addr_a] & ~(wr1_en & (wr1_addr == rd_addr_a));
  assign rd_busy_b = busy[rd_addr_b] & ~(wr1_en & (wr1_addr == rd_addr_b));
  assign busy_any  = |busy;

endmodule

// File: rtl/regfile_sb.sv
// Two-read / two-write register file with write-through bypass, load scoreboard and PC register.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                PC_IDX   = pc_idx_of(ADDR_W),
  parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(RESET_PC_DEF),
  parameter int                ZERO_R0  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              resv_en,
  input  logic [ADDR_W-1:0] resv_addr,
  input  logic              pc_we,
  input  logic [DATA_W-1:0] pc_next,
  output logic [DATA_W-1:0] pc_out,
  output logic              busy_any,
  output logic              err_waw
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [ADDR_W-1:0] ra   [2];
  logic [DATA_W-1:0] rd   [2];
  logic              collide;

  assign collide = wr0_en & wr1_en & (wr0_addr == wr1_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= (i == PC_IDX) ? RESET_PC : '0;
      err_waw <= 1'b0;
    end else begin
      err_waw <= collide;
      for (int i = 0; i < NREGS; i++) begin
        if (ZERO_R0 != 0 && i == 0)
          regs[i] <= '0;
        else if (wr0_en && wr0_addr == ADDR_W'(i))
          regs[i] <= wr0_data;
        else if (wr1_en && wr1_addr == ADDR_W'(i))
          regs[i] <= wr1_data;
        else if (pc_we && i == PC_IDX)
          regs[i] <= pc_next;
      end
    end
  end

  assign ra[0] = rd_addr_a;
  assign ra[1] = rd_addr_b;

  // Bypass order mirrors the write priority so a read sees what will be committed.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p] = regs[ra[p]];
      if (ZERO_R0 != 0 && ra[p] == '0)
        rd[p] = '0;
      else if (wr0_en && wr0_addr == ra[p])
        rd[p] = wr0_data;
      else if (wr1_en && wr1_addr == ra[p])
        rd[p] = wr1_data;
      else if (pc_we && ra[p] == ADDR_W'(PC_IDX))
        rd[p] = pc_next;
    end
  end

  assign rd_data_a = rd[0];
  assign rd_data_b = rd[1];
  assign pc_out    = regs[PC_IDX];

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .resv_en   (resv_en),
    .resv_addr (resv_addr),
    .wr1_en    (wr1_en),
    .wr1_addr  (wr1_addr),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_busy_a (rd_busy_a),
    .rd_busy_b (rd_busy_b),
    .busy_any  (busy_any)
  );

endmodule
